// File: rtl/sdrc_req_queue_pkg.sv
// rtl/sdrc_req_queue_pkg.sv - shared widths and helpers for the SDRAM request queue
package sdrc_req_queue_pkg;

    localparam int SDR_REQ_ID_W = 4;
    localparam int SDR_APP_AW   = 26;
    localparam int SDR_APP_RW   = 9;
    localparam int REQ_ENTRY_W  = SDR_APP_AW + SDR_APP_RW + SDR_REQ_ID_W + 2;

    // Packed entry layout, MSB first: {id, addr, len, wr_n, wrap}
    function automatic int req_entry_w(input int aw, input int rw, input int idw);
        return aw + rw + idw + 2;
    endfunction

endpackage

// File: rtl/sdrc_req_queue_id_alloc.sv
// rtl/sdrc_req_queue_id_alloc.sv - request ID free bitmap, lowest-free allocator and retire check
module sdrc_req_queue_id_alloc
    import sdrc_req_queue_pkg::*;
#(
    parameter int ID_W = SDR_REQ_ID_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc,
    output logic [ID_W-1:0] alloc_id,
    output logic            id_avail,
    input  logic            retire,
    input  logic [ID_W-1:0] retire_id,
    output logic            id_err
);

    localparam int NIDS = 1 << ID_W;

    logic [NIDS-1:0] free_map;
    logic [NIDS-1:0] free_nxt;

    // Scanning downward lets the lowest free index win.
    always_comb begin
        alloc_id = '0;
        for (int i = NIDS - 1; i >= 0; i--) begin
            if (free_map[i]) begin
                alloc_id = ID_W'(i);
            end
        end
    end

    assign id_avail = |free_map;

    always_comb begin
        free_nxt = free_map;
        if (alloc) begin
            free_nxt[alloc_id] = 1'b0;
        end
        if (retire && !free_map[retire_id]) begin
            free_nxt[retire_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_map <= '1;
            id_err   <= 1'b0;
        end else begin
            free_map <= free_nxt;
            if (retire && free_map[retire_id]) begin
                id_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdrc_req_queue.sv
// rtl/sdrc_req_queue.sv - request FIFO with ID tagging in front of the SDRAM request generator
module sdrc_req_queue
    import sdrc_req_queue_pkg::*;
#(
    parameter int APP_AW = SDR_APP_AW,
    parameter int APP_RW = SDR_APP_RW,
    parameter int ID_W   = SDR_REQ_ID_W,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              app_req,
    input  logic [APP_AW-1:0] app_req_addr,
    input  logic [APP_RW-1:0] app_req_len,
    input  logic              app_req_wr_n,
    input  logic              app_req_wrap,
    output logic              app_req_ack,
    output logic [ID_W-1:0]   app_req_tag,
    output logic              req,
    output logic [ID_W-1:0]   req_id,
    output logic [APP_AW-1:0] req_addr,
    output logic [APP_RW-1:0] req_len,
    output logic              req_wr_n,
    output logic              req_wrap,
    input  logic              req_ack,
    input  logic              xfr_done,
    input  logic [ID_W-1:0]   xfr_done_id,
    output logic [PTR_W:0]    q_count,
    output logic              q_full,
    output logic              id_err
);

    localparam int EW = req_entry_w(APP_AW, APP_RW, ID_W);

    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head_q;
    logic [EW-1:0]    head_nxt;
    logic [EW-1:0]    push_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [PTR_W:0]   count_after_pop;
    logic [PTR_W:0]   count_nxt;
    logic             id_avail;
    logic [ID_W-1:0]  alloc_id;
    logic             push;
    logic             pop;

    sdrc_req_queue_id_alloc #(
        .ID_W (ID_W)
    ) u_id_alloc (
        .clk       (clk),
        .reset     (reset),
        .alloc     (push),
        .alloc_id  (alloc_id),
        .id_avail  (id_avail),
        .retire    (xfr_done),
        .retire_id (xfr_done_id),
        .id_err    (id_err)
    );

    assign q_full      = (q_count == (PTR_W + 1)'(DEPTH));
    assign app_req_ack = app_req & ~q_full & id_avail & (app_req_len != '0) & ~reset;
    assign app_req_tag = alloc_id;
    assign push        = app_req_ack;
    assign pop         = req & req_ack;
    assign push_entry  = {alloc_id, app_req_addr, app_req_len, app_req_wr_n, app_req_wrap};

    // The head register looks one entry ahead; when the queue drains to empty a
    // concurrent push is the new head and must be taken from the write data.
    always_comb begin
        rd_nxt          = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_after_pop = pop ? q_count - (PTR_W + 1)'(1) : q_count;
        count_nxt       = push ? count_after_pop + (PTR_W + 1)'(1) : count_after_pop;
        head_nxt        = '0;
        if (count_after_pop == '0) begin
            if (push) begin
                head_nxt = push_entry;
            end
        end else begin
            head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            req     <= 1'b0;
            head_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_nxt;
            q_count <= count_nxt;
            req     <= (count_nxt != '0);
            head_q  <= head_nxt;
        end
    end

    assign {req_id, req_addr, req_len, req_wr_n, req_wrap} = head_q;

endmodule
